bcd_scan_counter: RTL

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

---
 rtl/bcd_disp_pkg.sv | 24 ++
 rtl/bcd_scan_counter_tick_gen.sv | 41 ++++
 rtl/bcd_scan_counter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared display definitions for the BCD scan counter.
//   bcd_t     : one BCD digit (4 bits)
//   SEG_BLANK : segment pattern for a dark digit
//   SEG7_TBL  : digit -> segments, a..g in [7:1], dp in [0], active-high
//   seg7_enc  : table lookup; any non-BCD code shows blank
package bcd_disp_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [7:0] SEG7_TBL [10] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
        8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6
    };

    function automatic logic [7:0] seg7_enc(input bcd_t d);
        logic [7:0] s;
        s = SEG_BLANK;
        if (d <= 4'd9) s = SEG7_TBL[d];
        return s;
    endfunction

endpackage

// File: rtl/bcd_scan_counter_tick_gen.sv
// tick_gen: modulo-DIV prescaler.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; counter -> 0, pulse forced low
//   en    : advance the counter this cycle
//   clr   : synchronous clear, wins over en, suppresses pulse
//   pulse : high in the cycle the counter leaves DIV-1 while enabled
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic pulse
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end

    // Combinational so the owner can act on the same edge the counter wraps.
    assign pulse = ~reset & ~clr & en & at_last;

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: prescaled up/down BCD counter with a multiplexed
// 7-segment scan output.
//   clk, reset : clock (rising edge), synchronous active-high reset
//   en         : gates the count prescaler
//   up         : 1 = increment, 0 = decrement (sampled on each tick)
//   load       : load load_val next edge; clears prescaler, no tick/wrap
//   load_val   : BCD value, digit 0 in [3:0]; non-BCD digits load as 0
//   count      : registered BCD count
//   tick, wrap : one-cycle pulses, high in the cycle ending in a step
//                (wrap only when the step rolls over)
//   seg, an    : registered segment data and active-low digit select
module bcd_scan_counter
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int TICK_DIV   = 2000000,
    parameter int SCAN_DIV   = 200,
    parameter int BLANK_LZ   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    tick,
    output logic                    wrap,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int ND = NUM_DIGITS;
    localparam int IW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(ND - 1);
    localparam logic [ND-1:0] AN_ONE   = ND'(1);

    logic [ND-1:0][3:0] count_q, count_d;
    logic [ND-1:0][3:0] inc_v, dec_v, ld_v;
    logic [ND-1:0]      blank;
    logic               cnt_tick, roll;

    // ---------------- count path ----------------
    tick_gen #(.DIV(TICK_DIV)) u_cnt_pre (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .pulse (cnt_tick)
    );

    // Per-digit ripple: carry/borrow enter from the digit below, the
    // leading-zero flag enters from the digit above.
    for (genvar g = 0; g < ND; g++) begin : g_dig
        logic cy_in, bw_in, hz_in;
        logic cy_out, bw_out, hz_out;
        logic [3:0] cur, lv;

        assign cur = count_q[g];
        assign lv  = load_val[4*g +: 4];

        if (g == 0) begin : g_lsd
            assign cy_in = 1'b1;
            assign bw_in = 1'b1;
        end else begin : g_hi
            assign cy_in = g_dig[g-1].cy_out;
            assign bw_in = g_dig[g-1].bw_out;
        end

        if (g == ND - 1) begin : g_msd
            assign hz_in = 1'b1;
        end else begin : g_lo
            assign hz_in = g_dig[g+1].hz_out;
        end

        assign cy_out = cy_in & (cur == 4'd9);
        assign bw_out = bw_in & (cur == 4'd0);
        assign hz_out = hz_in & (cur == 4'd0);

        assign inc_v[g] = !cy_in ? cur : ((cur == 4'd9) ? 4'd0 : cur + 4'd1);
        assign dec_v[g] = !bw_in ? cur : ((cur == 4'd0) ? 4'd9 : cur - 4'd1);
        assign ld_v[g]  = (lv > 4'd9) ? 4'd0 : lv;

        // Digit 0 always shows, even when the whole count is zero.
        assign blank[g] = (BLANK_LZ != 0) && (g != 0) && hz_out;
    end

    // Carry/borrow out of the top digit means every digit was 9 / 0.
    assign roll = up ? g_dig[ND-1].cy_out : g_dig[ND-1].bw_out;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = ld_v;
        else if (cnt_tick)
            count_d = up ? inc_v : dec_v;
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;
    assign tick  = cnt_tick;
    assign wrap  = cnt_tick & roll;

    // ---------------- scan path ----------------
    logic          scan_adv;
    logic [IW-1:0] idx_q, idx_d;
    logic          adv_q;
    logic [7:0]    seg_q, seg_d;
    logic [ND-1:0] an_q, an_d;

    tick_gen #(.DIV(SCAN_DIV)) u_scan_pre (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (1'b0),
        .pulse (scan_adv)
    );

    always_comb begin
        idx_d = idx_q;
        if (scan_adv)
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    // Outputs refresh only on the edge after an index advance, so the
    // display stays dark after reset until the first advance.
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        if (adv_q) begin
            an_d  = ~(AN_ONE << idx_q);
            seg_d = blank[idx_q] ? SEG_BLANK : seg7_enc(count_q[idx_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            adv_q <= 1'b0;
            an_q  <= '1;
            seg_q <= SEG_BLANK;
        end else begin
            idx_q <= idx_d;
            adv_q <= scan_adv;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
